instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  Fetch stage of the 16-bit pipelined CPU. Owns the PC, issues one-outstanding reads to instruction
//  memory, and holds each returned word in a one-entry output buffer (instruction, PC, valid).
//  Sits directly upstream of the IF/ID pipeline register. Honours the hazard-unit stall and the
//  branch redirect/flush from execute.
// PARAMETERS
//  WIDTH     16       data/address width of instruction and PC
//  RESET_PC  16'h0000 PC value loaded on reset
//  PC_STEP   1        PC increment per instruction (word-addressed memory)
//  NOP_INSTR 16'h0000 instruction driven while out_valid=0
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-high reset
//  stall          in   1      1 = downstream does not consume out_* this cycle
//  branch_taken   in   1      1-cycle pulse: redirect PC, flush fetched/in-flight instruction
//  branch_target  in   WIDTH  new PC when branch_taken=1
//  imem_req       out  1      read request valid
//  imem_addr      out  WIDTH  read address (= PC)
//  imem_ready     in   1      memory accepts request this cycle (handshake: req && ready)
//  imem_rvalid    in   1      read data valid
//  imem_rdata     in   WIDTH  read data
//  out_instruction out WIDTH  fetched instruction (NOP_INSTR when invalid)
//  out_PC         out  WIDTH  address of out_instruction
//  out_valid      out  1      out_* holds a real instruction
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, imem_req=0, out_valid=0, out_instruction=NOP_INSTR, out_PC=0.
//  FSM: IDLE -> REQ (unconditional, next cycle). IDLE ignores imem_rvalid (drops responses in flight
//   across a mid-operation reset).
//  REQ: imem_req=1 iff buffer free (out_valid=0, or out_valid=1 && stall=0); imem_addr=pc.
//   req && ready -> WAIT. Otherwise stay REQ; imem_addr tracks pc.
//  WAIT: imem_req=0. On imem_rvalid: load out_instruction=rdata, out_PC=pc, out_valid=1,
//   pc=pc+PC_STEP (mod 2^WIDTH, 16'hFFFF+1 -> 16'h0000), -> REQ.
//  FLUSH_WAIT: imem_req=0. On imem_rvalid: discard data, -> REQ (pc already redirected).
//  Consume: out_valid && !stall clears out_valid (unless a new word loads same cycle; load wins).
//  Stall with out_valid=1: out_* held stable, no new request issued.
//  branch_taken (priority over stall and rvalid): pc=branch_target, out_valid=0 (out_instruction=NOP_INSTR);
//   in WAIT, or in REQ with handshake completing same cycle -> FLUSH_WAIT; otherwise -> REQ.
//   Same-cycle rvalid in WAIT is discarded -> REQ.
//  Latency: req accepted cycle t, rvalid earliest t+1, out_valid at t+2. Max throughput 1 instr / 2 cycles.
//  imem_rvalid in REQ: ignored (protocol violation; flagged by bench assertion).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetch_count[31:0] (increments on each consume) and
//   perf_stall_cycles[31:0] (increments each cycle stall && out_valid). Both reset to 0, wrap at 2^32,
//   do not count across flush.
//  Undefined: ports and counters absent; otherwise identical behaviour.
// STRUCTURE
//  cpu_pkg: fetch_state_t enum {IDLE, REQ, WAIT, FLUSH_WAIT}, NOP_INSTR, RESET_PC defaults.
//  Sub-module fetch_pc_reg: PC register with next-PC mux (reset / redirect / increment / hold).
//  Top holds FSM, output buffer, optional perf counters.
// TESTING
//  1 Reset, imem_ready=1, rvalid 1 cycle after accept, stall=0 -> out_PC 0,1,2 with rdata, out_valid
//    every 2nd cycle.
//  2 stall=1 while out_valid=1 for 5 cycles -> out_* stable, imem_req=0; release -> consumed, next req issued.
//  3 branch_taken, target 16'h0040, in WAIT -> next rvalid dropped, next imem_addr=16'h0040, out_valid=0.
//  4 RESET_PC=16'hFFFF, two fetches -> out_PC 16'hFFFF then 16'h0000.
//  5 reset asserted in WAIT, rvalid arrives during/after reset -> ignored; first fetch from RESET_PC.
//  6 FETCH_PERF_CNT_EN: 3 consumes + 4 stalled cycles -> perf_fetch_count=3, perf_stall_cycles=4.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the 16-bit pipelined CPU front end.
// Holds the fetch FSM state encoding, the PC-select encoding used by the
// PC register, and the reset/NOP defaults the fetch stage is built with.
package cpu_pkg;

  localparam int unsigned CPU_WIDTH = 16;

  localparam logic [CPU_WIDTH-1:0] RESET_PC_DEFAULT  = 16'h0000;
  localparam logic [CPU_WIDTH-1:0] NOP_INSTR_DEFAULT = 16'h0000;
  localparam int unsigned          PC_STEP_DEFAULT   = 1;

  // Fetch sequencing: IDLE for one cycle after reset, REQ while a read may be
  // issued, WAIT for a live response, FLUSH_WAIT for a response to be dropped.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQ        = 2'd1,
    WAIT       = 2'd2,
    FLUSH_WAIT = 2'd3
  } fetch_state_t;

  // Next-PC selection handed from the FSM to the PC register.
  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_REDIRECT = 2'd1,
    PC_INCR     = 2'd2
  } pc_sel_t;

  // The one-entry output buffer can take a new word when it is empty or when
  // its current word is being consumed this cycle.
  function automatic logic buffer_free(input logic valid, input logic stall);
    return !valid || !stall;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter for the fetch stage: reset value, branch redirect,
// fixed-step increment (wraps modulo 2^WIDTH) or hold.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH    = CPU_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned      PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  pc_sel_t          pc_sel_i,
  input  logic [WIDTH-1:0] target_i,
  output logic [WIDTH-1:0] pc_o
);

  localparam logic [WIDTH-1:0] PC_INC = WIDTH'(PC_STEP);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Next-PC mux; the addition simply wraps at the top of the address space.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel_i)
      PC_REDIRECT: pc_d = target_i;
      PC_INCR:     pc_d = pc_q + PC_INC;
      default:     pc_d = pc_q;
    endcase
  end

  // PC register, loaded with RESET_PC on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage of the 16-bit pipelined CPU.
// Owns the PC, keeps at most one instruction-memory read outstanding and
// parks each returned word in a one-entry buffer feeding the IF/ID register.
// A taken branch redirects the PC, empties the buffer and causes any read
// still in flight to be discarded when its data returns.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetch_count (words
// consumed downstream) and perf_stall_cycles (cycles a valid word sat stalled).
module instruction_fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH     = CPU_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned      PC_STEP   = PC_STEP_DEFAULT,
  parameter logic [WIDTH-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] out_instruction,
  output logic [WIDTH-1:0] out_PC,
  output logic             out_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch_count,
  output logic [31:0]      perf_stall_cycles
`endif
);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  pc_sel_t          pc_sel;
  logic [WIDTH-1:0] pc;
  logic             load;
  logic             consume;

  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_instr_q;
  logic [WIDTH-1:0] out_instr_d;
  logic [WIDTH-1:0] out_pc_q;
  logic [WIDTH-1:0] out_pc_d;

  fetch_pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .pc_sel_i (pc_sel),
    .target_i (branch_target),
    .pc_o     (pc)
  );

  assign imem_addr = pc;
  assign consume   = out_valid_q && !stall;

  // Fetch FSM: request issue, response capture and branch flush handling.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    pc_sel   = PC_HOLD;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        // Any response still arriving from before reset is ignored here.
        state_d = REQ;
      end
      REQ: begin
        imem_req = buffer_free(out_valid_q, stall);
        if (imem_req && imem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
          load    = 1'b1;
          pc_sel  = PC_INCR;
        end
      end
      FLUSH_WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect overrides everything above. A read that is outstanding, or
    // that is being accepted right now, must have its data thrown away.
    if (branch_taken) begin
      pc_sel = PC_REDIRECT;
      load   = 1'b0;
      if (state_q == WAIT || state_q == FLUSH_WAIT) begin
        state_d = imem_rvalid ? REQ : FLUSH_WAIT;
      end else if (state_q == REQ && imem_req && imem_ready) begin
        state_d = FLUSH_WAIT;
      end else begin
        state_d = REQ;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output buffer next state: flush beats load, load beats consume.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (branch_taken) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_instr_d = imem_rdata;
      out_pc_d    = pc;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  // Output buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // Downstream never sees a stale word: an empty buffer presents a NOP.
  assign out_instruction = out_valid_q ? out_instr_q : NOP_INSTR;
  assign out_PC          = out_pc_q;
  assign out_valid       = out_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Performance counters; a flushing cycle is neither a consume nor a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (consume && !branch_taken) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (stall && out_valid_q && !branch_taken) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_count  = fetch_cnt_q;
  assign perf_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage.
// A behavioural model of the fetch stage runs alongside the DUT and is
// compared every cycle; directed phases add literal expectations.
// Build with FETCH_PERF_CNT_EN defined to exercise the perf counters.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'hDEAD;

  logic        imem_req, imem_req2;
  logic [15:0] imem_addr, imem_addr2;
  logic [15:0] out_instruction, out_instruction2;
  logic [15:0] out_PC, out_PC2;
  logic        out_valid, out_valid2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_count, perf_stall_cycles;
  logic [31:0] perf_fetch_count2, perf_stall_cycles2;
`endif

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch_stage u_dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .out_instruction (out_instruction),
    .out_PC          (out_PC),
    .out_valid       (out_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_count  (perf_fetch_count),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Second instance shares every input; only its PC sequence is examined.
  instruction_fetch_stage #(.RESET_PC(16'hFFFF)) u_dut_wrap (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req2),
    .imem_addr       (imem_addr2),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .out_instruction (out_instruction2),
    .out_PC          (out_PC2),
    .out_valid       (out_valid2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_count  (perf_fetch_count2),
    .perf_stall_cycles (perf_stall_cycles2)
`endif
  );

  // Memory contents: byte swap of the address, xor a constant.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_pc, m_instr, m_opc;
  logic        m_valid, m_inflight, m_drop, m_idle;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] m_fetch, m_stallc;
`endif
  wire m_req = !m_idle && !m_inflight && (!m_valid || !stall);
  wire m_hs  = m_req && imem_ready;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= 16'h0000; m_instr <= 16'h0000; m_opc <= 16'h0000;
      m_valid <= 1'b0; m_inflight <= 1'b0; m_drop <= 1'b0; m_idle <= 1'b1;
`ifdef FETCH_PERF_CNT_EN
      m_fetch <= 32'd0; m_stallc <= 32'd0;
`endif
    end else begin
      m_idle <= 1'b0;
      if (branch_taken) begin
        m_pc    <= branch_target;
        m_valid <= 1'b0;
        if (m_hs) begin
          m_inflight <= 1'b1; m_drop <= 1'b1;
        end else if (m_inflight && imem_rvalid) begin
          m_inflight <= 1'b0; m_drop <= 1'b0;
        end else if (m_inflight) begin
          m_drop <= 1'b1;
        end
      end else begin
        if (m_inflight && imem_rvalid) begin
          m_inflight <= 1'b0; m_drop <= 1'b0;
          if (!m_drop) begin
            m_valid <= 1'b1; m_instr <= mem_word(m_pc); m_opc <= m_pc; m_pc <= m_pc + 16'd1;
          end
        end else if (m_valid && !stall) begin
          m_valid <= 1'b0;
        end
        if (m_hs) begin
          m_inflight <= 1'b1; m_drop <= 1'b0;
        end
`ifdef FETCH_PERF_CNT_EN
        if (m_valid && !stall) m_fetch <= m_fetch + 32'd1;
        if (m_valid && stall)  m_stallc <= m_stallc + 32'd1;
`endif
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en && !reset) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("out_instruction", {16'd0, out_instruction}, {16'd0, m_instr});
        chk("out_PC", {16'd0, out_PC}, {16'd0, m_opc});
      end else begin
        chk("nop_when_invalid", {16'd0, out_instruction}, 32'h0000);
      end
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
      if (m_req) chk("imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
      if (imem_rvalid && !m_inflight && !m_idle) begin
        fails++;
        $display("FAIL protocol: imem_rvalid with no read outstanding");
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch_count", perf_fetch_count, m_fetch);
      chk("perf_stall_cycles", perf_stall_cycles, m_stallc);
`endif
    end
  end

  // ---------------- memory responder / stimulus ----------------
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_addr = 16'h0000;
  int          resp_delay = 1;

  // One clock: sample handshake mid-cycle, then drive the response after the edge.
  task automatic cyc();
    logic        hs;
    logic [15:0] a;
    @(negedge clk);
    hs = imem_req && imem_ready;
    a  = imem_addr;
    @(posedge clk);
    #2;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'hDEAD;
    if (hs) begin
      pend = 1'b1; pend_cnt = resp_delay; pend_addr = a;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        pend = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr);
      end
    end
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    chk(name, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    int n;
    #1 reset = 1'b1;
    #1;
    // reset state
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst out_PC", {16'd0, out_PC}, 32'h0000);
    chk("rst out_instruction", {16'd0, out_instruction}, 32'h0000);
    chk("rst out_PC wrap inst", {16'd0, out_PC2}, 32'h0000);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    check_en = 1'b1;

    // 1: straight-line fetch
    wait_valid("t1 w0 valid", n);
    chk("t1 w0 pc", {16'd0, out_PC}, 32'h0000);
    chk("t1 w0 instr", {16'd0, out_instruction}, 32'h1234);
    chk("t4 wrap w0 pc", {16'd0, out_PC2}, 32'hFFFF);
    cyc();
    wait_valid("t1 w1 valid", n);
    chk("t1 spacing", n, 1);
    chk("t1 w1 pc", {16'd0, out_PC}, 32'h0001);
    chk("t1 w1 instr", {16'd0, out_instruction}, 32'h1334);
    chk("t4 wrap w1 pc", {16'd0, out_PC2}, 32'h0000);
    cyc();
    wait_valid("t1 w2 valid", n);
    chk("t1 w2 pc", {16'd0, out_PC}, 32'h0002);
    chk("t1 w2 instr", {16'd0, out_instruction}, 32'h1034);

    // 2: stall with a valid word held
    stall = 1'b1;
    #1 chk("t2 req off", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2 hold valid", {31'd0, out_valid}, 32'd1);
      chk("t2 hold pc", {16'd0, out_PC}, 32'h0002);
      chk("t2 hold instr", {16'd0, out_instruction}, 32'h1034);
      chk("t2 hold req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    resp_delay = 3;
    #1;
    chk("t2 release req", {31'd0, imem_req}, 32'd1);
    chk("t2 release addr", {16'd0, imem_addr}, 32'h0003);
    cyc();
    chk("t2 consumed", {31'd0, out_valid}, 32'd0);

    // 3: branch while waiting for a response
    branch_target = 16'h0040;
    branch_taken  = 1'b1;
    resp_delay    = 1;
    cyc();
    branch_taken = 1'b0;
    #1;
    chk("t3 flush valid", {31'd0, out_valid}, 32'd0);
    chk("t3 flush req", {31'd0, imem_req}, 32'd0);
    n = 0;
    while (!imem_req && n < 8) begin
      cyc();
      n++;
    end
    chk("t3 req after drop", {31'd0, imem_req}, 32'd1);
    chk("t3 drop cycles", n, 2);
    chk("t3 redirect addr", {16'd0, imem_addr}, 32'h0040);
    chk("t3 dropped not loaded", {31'd0, out_valid}, 32'd0);
    wait_valid("t3 valid", n);
    chk("t3 pc", {16'd0, out_PC}, 32'h0040);
    chk("t3 instr", {16'd0, out_instruction}, 32'h5234);

    // 5: reset while a read is outstanding
    resp_delay = 2;
    cyc();
    reset = 1'b1;
    pend  = 1'b0;
    pend_cnt = 0;
    #1;
    chk("t5 rst valid", {31'd0, out_valid}, 32'd0);
    chk("t5 rst req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 16'hBEEF;
    cyc();
    cyc();
    reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 16'hBEEF;
    resp_delay  = 1;
    cyc();
    wait_valid("t5 valid", n);
    chk("t5 pc", {16'd0, out_PC}, 32'h0000);
    chk("t5 instr", {16'd0, out_instruction}, 32'h1234);
    chk("t5 wrap pc", {16'd0, out_PC2}, 32'hFFFF);

    // 6: three consumes and four stalled cycles since reset
    cyc();
    wait_valid("t6 w1 valid", n);
    cyc();
    wait_valid("t6 w2 valid", n);
    imem_ready = 1'b0;
    stall = 1'b1;
    repeat (4) cyc();
    stall = 1'b0;
    cyc();
    chk("t6 consumed", {31'd0, out_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6 perf_fetch_count", perf_fetch_count, 32'd3);
    chk("t6 perf_stall_cycles", perf_stall_cycles, 32'd4);
`endif
    imem_ready = 1'b1;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
